// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Used by the receiver and the transmitter.
package uart_pkg;

  localparam int UartDataWidth = 8;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } uart_rx_state_e;

  function automatic int clocks_per_bit(
    input int freq,
    input int baud
  );
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-delivery bundle between the UART receiver
// and its consumer on the system bus side.
interface uart_rx_if;

  logic [uart_pkg::UartDataWidth-1:0] rx_data_o;
  logic rx_valid_o;
  logic rx_ready_i;
  logic rx_frame_err_o;
  logic rx_overrun_o;
  logic rx_busy_o;

  modport master (
    output rx_data_o,
    output rx_valid_o,
    input  rx_ready_i,
    output rx_frame_err_o,
    output rx_overrun_o,
    output rx_busy_o
  );

  modport slave (
    input  rx_data_o,
    input  rx_valid_o,
    output rx_ready_i,
    input  rx_frame_err_o,
    input  rx_overrun_o,
    input  rx_busy_o
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pins.
// Reset value is a parameter so idle-high lines stay quiet.
module sync_2ff #(
  parameter logic ResetValue = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= ResetValue;
      q    <= ResetValue;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle high,
// with a single-entry valid/ready output register.
module uart_rx import uart_pkg::*; #(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200
) (
  input  logic      clk_sys_i,
  input  logic      rst_sys_ni,
  input  logic      uart_rx_i,
  uart_rx_if.master bus
);

  localparam int ClocksPerBit =
    clocks_per_bit(ClockFrequency, BaudRate);
  localparam int CntW = $clog2(ClocksPerBit);
  localparam int IdxW = $clog2(UartDataWidth);

  localparam logic [CntW-1:0] HalfLoad =
    CntW'(ClocksPerBit / 2 - 1);
  localparam logic [CntW-1:0] FullLoad =
    CntW'(ClocksPerBit - 1);
  localparam logic [IdxW-1:0] LastIdx =
    IdxW'(UartDataWidth - 1);

  generate
    if (ClocksPerBit < 4) begin : g_cpb_check
      $error("uart_rx: ClocksPerBit must be >= 4");
    end
  endgenerate

  uart_rx_state_e state;
  logic [CntW-1:0] cnt;
  logic [IdxW-1:0] idx;
  logic [UartDataWidth-1:0] shift;
  logic [UartDataWidth-1:0] data_q;
  logic valid_q;
  logic ferr_q;
  logic ovr_q;
  logic rx_sync;
  logic rx_prev;
  logic fall;
  logic tick;
  logic done;
  logic bad;

  sync_2ff #(
    .ResetValue(1'b1)
  ) u_sync (
    .clk  (clk_sys_i),
    .rst_n(rst_sys_ni),
    .d    (uart_rx_i),
    .q    (rx_sync)
  );

  // prev resets high so reset release never looks like a start edge
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) rx_prev <= 1'b1;
    else             rx_prev <= rx_sync;
  end

  assign fall = !rx_sync && rx_prev;
  assign tick = (cnt == '0);
  assign done = (state == RxStop) && tick && rx_sync;
  assign bad  = (state == RxStop) && tick && !rx_sync;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state <= RxIdle;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      unique case (state)
        RxIdle: begin
          if (fall) begin
            state <= RxStart;
            cnt   <= HalfLoad;
          end
        end
        RxStart: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else if (!rx_sync) begin
            state <= RxData;
            cnt   <= FullLoad;
            idx   <= '0;
          end else begin
            state <= RxIdle;
          end
        end
        RxData: begin
          if (!tick) begin
            cnt <= cnt - 1'b1;
          end else begin
            shift[idx] <= rx_sync;
            cnt        <= FullLoad;
            idx        <= idx + 1'b1;
            if (idx == LastIdx) state <= RxStop;
          end
        end
        RxStop: begin
          if (!tick) cnt <= cnt - 1'b1;
          else       state <= RxIdle;
        end
        default: state <= RxIdle;
      endcase
    end
  end

  // a handshake in the completion cycle frees the slot for the new byte
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= bad;
      ovr_q  <= done && valid_q && !bus.rx_ready_i;
      if (done && (!valid_q || bus.rx_ready_i)) begin
        data_q  <= shift;
        valid_q <= 1'b1;
      end else if (valid_q && bus.rx_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.rx_data_o      = data_q;
  assign bus.rx_valid_o     = valid_q;
  assign bus.rx_frame_err_o = ferr_q;
  assign bus.rx_overrun_o   = ovr_q;
  assign bus.rx_busy_o      = (state != RxIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit.
// Line is driven 1ns after posedge; outputs sampled on negedge or +1ns.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rx_line = 1'b1;

  uart_rx_if bus ();

  uart_rx #(
    .ClockFrequency(50_000_000),
    .BaudRate      (5_000_000)
  ) dut (
    .clk_sys_i (clk),
    .rst_sys_ni(rst_n),
    .uart_rx_i (rx_line),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int passed = 0;
  int total = 0;
  int e0 = 0;
  int n_rise = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int rise_cyc = 0;
  logic last_valid = 1'b0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (bus.rx_frame_err_o === 1'b1) n_ferr++;
    if (bus.rx_overrun_o === 1'b1) n_ovr++;
    if (bus.rx_valid_o === 1'b1 && !last_valid) begin
      n_rise++;
      rise_cyc = cyc;
    end
    if (bus.rx_valid_o === 1'b1 && bus.rx_ready_i === 1'b1)
      got_q.push_back(bus.rx_data_o);
    last_valid = (bus.rx_valid_o === 1'b1);
  end

  task automatic clear_mon();
    n_rise = 0;
    n_ferr = 0;
    n_ovr = 0;
    rise_cyc = 0;
    got_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_line = b;
    idle(10);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    e0 = cyc + 1;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic drain();
    bus.rx_ready_i = 1'b1;
    idle(2);
    bus.rx_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    idle(3);
    total++;
    if (bus.rx_data_o !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.rx_data_o);
    else passed++;
    total++;
    if (bus.rx_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.rx_valid_o);
    else passed++;
    total++;
    if (bus.rx_frame_err_o !== 1'b0) $display("FAIL reset_ferr: got %b want 0", bus.rx_frame_err_o);
    else passed++;
    total++;
    if (bus.rx_overrun_o !== 1'b0) $display("FAIL reset_ovr: got %b want 0", bus.rx_overrun_o);
    else passed++;
    total++;
    if (bus.rx_busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.rx_busy_o);
    else passed++;
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_single();
    clear_mon();
    bus.rx_ready_i = 1'b0;
    send_frame(8'hA5, 1'b1);
    total++;
    if (rise_cyc - e0 !== 97) $display("FAIL single_latency: got %0d want 97", rise_cyc - e0);
    else passed++;
    total++;
    if (bus.rx_data_o !== 8'hA5) $display("FAIL single_data: got %h want a5", bus.rx_data_o);
    else passed++;
    total++;
    if (bus.rx_valid_o !== 1'b1) $display("FAIL single_valid: got %b want 1", bus.rx_valid_o);
    else passed++;
    total++;
    if (n_ferr !== 0 || n_ovr !== 0) $display("FAIL single_errs: got ferr=%0d ovr=%0d want 0 0", n_ferr, n_ovr);
    else passed++;
    idle(30);
    total++;
    if (bus.rx_valid_o !== 1'b1) $display("FAIL single_hold: got %b want 1", bus.rx_valid_o);
    else passed++;
    bus.rx_ready_i = 1'b1;
    idle(1);
    bus.rx_ready_i = 1'b0;
    total++;
    if (bus.rx_valid_o !== 1'b0) $display("FAIL single_clear: got %b want 0", bus.rx_valid_o);
    else passed++;
    total++;
    if (got_q.size() !== 1) $display("FAIL single_accepts: got %0d want 1", got_q.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp[0] = 8'h00;
    exp[1] = 8'hFF;
    exp[2] = 8'h3C;
    clear_mon();
    bus.rx_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
    idle(20);
    bus.rx_ready_i = 1'b0;
    total++;
    if (n_rise !== 3) $display("FAIL b2b_pulses: got %0d want 3", n_rise);
    else passed++;
    total++;
    if (got_q.size() !== 3) $display("FAIL b2b_count: got %0d want 3", got_q.size());
    else passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got_q.size() <= i || got_q[i] !== exp[i])
        $display("FAIL b2b_data%0d: got %h want %h", i, (got_q.size() > i) ? got_q[i] : 8'hxx, exp[i]);
      else passed++;
    end
    total++;
    if (n_ovr !== 0) $display("FAIL b2b_ovr: got %0d want 0", n_ovr);
    else passed++;
  endtask

  task automatic test_overrun();
    clear_mon();
    bus.rx_ready_i = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(20);
    total++;
    if (n_ovr !== 1) $display("FAIL ovr_pulses: got %0d want 1", n_ovr);
    else passed++;
    total++;
    if (bus.rx_data_o !== 8'h11) $display("FAIL ovr_data: got %h want 11", bus.rx_data_o);
    else passed++;
    total++;
    if (bus.rx_valid_o !== 1'b1) $display("FAIL ovr_valid: got %b want 1", bus.rx_valid_o);
    else passed++;
    drain();
  endtask

  task automatic test_frame_err();
    clear_mon();
    bus.rx_ready_i = 1'b0;
    send_frame(8'h55, 1'b0);
    idle(190);
    total++;
    if (n_ferr !== 1) $display("FAIL ferr_pulses: got %0d want 1", n_ferr);
    else passed++;
    total++;
    if (n_rise !== 0) $display("FAIL ferr_valid: got %0d want 0", n_rise);
    else passed++;
    total++;
    if (bus.rx_busy_o !== 1'b0) $display("FAIL ferr_break_busy: got %b want 0", bus.rx_busy_o);
    else passed++;
    rx_line = 1'b1;
    idle(20);
    send_frame(8'h5A, 1'b1);
    idle(5);
    total++;
    if (bus.rx_data_o !== 8'h5A || n_rise !== 1)
      $display("FAIL ferr_recover: got %h/%0d want 5a/1", bus.rx_data_o, n_rise);
    else passed++;
    total++;
    if (n_ferr !== 1) $display("FAIL ferr_after: got %0d want 1", n_ferr);
    else passed++;
    drain();
  endtask

  task automatic test_glitch();
    clear_mon();
    rx_line = 1'b0;
    idle(3);
    rx_line = 1'b1;
    idle(2);
    total++;
    if (bus.rx_busy_o !== 1'b1) $display("FAIL glitch_busy_on: got %b want 1", bus.rx_busy_o);
    else passed++;
    idle(4);
    total++;
    if (bus.rx_busy_o !== 1'b0) $display("FAIL glitch_busy_off: got %b want 0", bus.rx_busy_o);
    else passed++;
    idle(120);
    total++;
    if (n_rise !== 0) $display("FAIL glitch_valid: got %0d want 0", n_rise);
    else passed++;
    total++;
    if (n_ferr !== 0) $display("FAIL glitch_ferr: got %0d want 0", n_ferr);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'h96;
    clear_mon();
    bus.rx_ready_i = 1'b0;
    send_frame(8'h3C, 1'b1);
    idle(5);
    total++;
    if (bus.rx_valid_o !== 1'b1) $display("FAIL rmid_pre_valid: got %b want 1", bus.rx_valid_o);
    else passed++;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx_line = d[4];
    idle(5);
    total++;
    if (bus.rx_busy_o !== 1'b1) $display("FAIL rmid_pre_busy: got %b want 1", bus.rx_busy_o);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.rx_data_o !== 8'h00 || bus.rx_valid_o !== 1'b0)
      $display("FAIL rmid_out: got %h/%b want 00/0", bus.rx_data_o, bus.rx_valid_o);
    else passed++;
    total++;
    if (bus.rx_busy_o !== 1'b0 || bus.rx_frame_err_o !== 1'b0 || bus.rx_overrun_o !== 1'b0)
      $display("FAIL rmid_flags: got %b%b%b want 000", bus.rx_busy_o, bus.rx_frame_err_o, bus.rx_overrun_o);
    else passed++;
    idle(3);
    rx_line = 1'b1;
    rst_n = 1'b1;
    idle(20);
    clear_mon();
    send_frame(d, 1'b1);
    idle(5);
    total++;
    if (bus.rx_data_o !== 8'h96) $display("FAIL rmid_data: got %h want 96", bus.rx_data_o);
    else passed++;
    total++;
    if (n_rise !== 1 || n_ferr !== 0)
      $display("FAIL rmid_events: got rise=%0d ferr=%0d want 1 0", n_rise, n_ferr);
    else passed++;
  endtask

  initial begin
    bus.rx_ready_i = 1'b0;
    rx_line = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver for the Ibex demo system: it samples the board's asynchronous RX pin and delivers bytes to the system bus side over a valid/ready handshake. It is the receive counterpart of the system's existing `uart_tx_o` path. It sits in the board-level top between the RX pin and the demo system's UART peripheral. Frame format is fixed at 8N1, LSB first, with the line idling high.

## Interface
Parameters:
- `ClockFrequency`, default 50_000_000: `clk_sys_i` frequency in Hz.
- `BaudRate`, default 115_200: line rate in bit/s.
- `ClocksPerBit` (localparam) = `ClockFrequency / BaudRate`, integer division. Elaboration fails if it is below 4.

Ports (clock is `clk_sys_i`; reset is `rst_sys_ni`, asynchronous, active-low):
- `clk_sys_i`  in  1  system clock.
- `rst_sys_ni`  in  1  asynchronous active-low reset.
- `uart_rx_i`  in  1  raw RX pin, asynchronous to the clock, idle high.
- `rx_data_o`  out  8  received byte; stable while `rx_valid_o` is high.
- `rx_valid_o`  out  1  byte available; held high until accepted.
- `rx_ready_i`  in  1  consumer accepts the byte when `rx_valid_o && rx_ready_i`.
- `rx_frame_err_o`  out  1  one-cycle pulse when the stop bit is sampled low.
- `rx_overrun_o`  out  1  one-cycle pulse when a completed byte is dropped.
- `rx_busy_o`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Synchronizer.** A two-flop synchronizer on `uart_rx_i` resets to 1. A `prev` register holds the previous synchronized value and also resets to 1, so reset release never produces a false start edge.
- **IDLE.** A falling edge (sync = 0, `prev` = 1) moves the FSM to START and loads the counter with `ClocksPerBit/2 - 1`.
- **START.** The counter decrements each cycle. At 0 the line is sampled:
  - 0: go to DATA, counter = `ClocksPerBit - 1`, bit index = 0.
  - 1: glitch; return to IDLE with no output.
- **DATA.** At counter 0, shift the sample into bit [index] (LSB first) and reload the counter. After index 7, go to STOP.
- **STOP.** At counter 0, sample the line:
  - 1: byte complete.
  - 0: pulse `rx_frame_err_o` and discard the byte.
  - In both cases return to IDLE the same edge. A held-low break does not retrigger, because a new high→low edge is required.
- **Output holding register.** Single entry.
  - Completion with the register empty: load it and set valid.
  - Completion while valid && !ready: keep the old byte, drop the new one, pulse `rx_overrun_o`.
  - Completion in the same cycle as a handshake: load the new byte, valid stays high, no overrun.
  - Handshake alone: valid clears on the next edge.
- **Reset values.** `rx_data_o` = 0, `rx_valid_o` = 0, `rx_frame_err_o` = 0, `rx_overrun_o` = 0, `rx_busy_o` = 0, FSM = IDLE.
- **Reset mid-frame.** The partial byte is lost. After release, reception resumes only on the next falling edge.

## Timing
- Let E0 be the first clock edge at which the first synchronizer flop captures 0.
  - START is entered at E0+2.
  - The start-bit sample is at E0+2+`ClocksPerBit/2`.
  - Data bit i is sampled at E0+2+`ClocksPerBit/2`+(i+1)·`ClocksPerBit`.
  - The stop-bit sample is at E0+2+`ClocksPerBit/2`+9·`ClocksPerBit`.
- `rx_valid_o`, `rx_frame_err_o` and `rx_overrun_o` all update at the stop-sample edge.
- Back-to-back frames with zero idle time are received without loss, because the FSM is in IDLE again before the next start edge is synchronized.
- Input pulses low for fewer than `ClocksPerBit/2 - 2` cycles are always rejected.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- `uart_pkg` holds:
  - the `uart_rx_state_e` enum (IDLE, START, DATA, STOP);
  - the `ClocksPerBit` function, shared with the transmitter;
  - the `UartDataWidth` = 8 constant.
- Sub-module `sync_2ff` (parameterized reset value) implements the synchronizer and can be reused for the SW/BTN inputs.
- The FSM, counter, shift register and output register stay in `uart_rx`.

## Test plan
All scenarios use ClockFrequency = 50_000_000 and BaudRate = 5_000_000, so ClocksPerBit = 10.
- **Single byte:** send 0xA5 with stop = 1, `rx_ready_i` = 0. `rx_valid_o` rises at E0+97, `rx_data_o` = 0xA5, no error pulses; it stays high until ready is driven, then clears next cycle.
- **Back-to-back:** send 0x00, 0xFF, 0x3C with no idle gap, ready = 1. Three valid pulses occur with data in that order.
- **Overrun:** send 0x11 then 0x22 with ready = 0. `rx_overrun_o` pulses once at the second stop sample, and `rx_data_o` stays 0x11.
- **Frame error and break:** send 0x55 with stop = 0, then hold the line low for 200 cycles. Exactly one `rx_frame_err_o` pulse, no valid, and no retrigger until the line goes high and then low again.
- **Glitch:** a 3-cycle low pulse gives no valid and no error, and `rx_busy_o` returns to 0 by E0+8.
- **Reset mid-frame:** assert `rst_sys_ni` during bit 4 of 0x96. All outputs read 0. A subsequent 0x96 frame is received correctly with data = 0x96.
